// File: rtl/ravan_key_sequencer.sv
// RAVAN key sequencer: streams a latched multi-word key into a register-mapped hash core and gathers the readback.
// Optional build macro RAVAN_WORD_MIX_EN: XOR the last key word with mix_word at start.
module ravan_key_sequencer #(
   parameter int unsigned KEY_WORDS   = 16,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned WR_BASE     = 0,
   parameter int unsigned RD_BASE     = 0,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_start,
   input  logic [32*KEY_WORDS-1:0]   i_key_in,
   input  logic [31:0]               i_mix_word,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_err,
   output logic [32*KEY_WORDS-1:0]   o_hash_out,
   output logic                      o_bus_cs,
   output logic                      o_bus_we,
   output logic [ADDR_W-1:0]         o_bus_addr,
   output logic [31:0]               o_bus_wdata,
   input  logic [31:0]               i_bus_rdata,
   input  logic                      i_bus_error
);

   localparam int unsigned IDX_W = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
   localparam int unsigned KEY_W = 32 * KEY_WORDS;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_WAIT,
      S_READ,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t              r_state;
   logic [IDX_W-1:0]    r_idx;
   logic [7:0]          r_cnt;
   logic [31:0]         r_key [KEY_WORDS];
   logic [KEY_W-1:0]    r_hash;
   logic                r_busy;
   logic                r_done;
   logic                r_err;
   logic                r_cs;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [31:0]         r_wdata;

   logic [31:0]         w_key_lat [KEY_WORDS];
   logic [IDX_W-1:0]    w_idx_nxt;
   logic [ADDR_W-1:0]   w_wr_addr_nxt;
   logic [ADDR_W-1:0]   w_rd_addr;

   // Key as it will be latched on an accepted start (tweak applied to the last word when enabled)
   always_comb begin
      for (int i = 0; i < KEY_WORDS; i++) begin
         w_key_lat[i] = i_key_in[i*32 +: 32];
      end
`ifdef RAVAN_WORD_MIX_EN
      w_key_lat[KEY_WORDS-1] = i_key_in[(KEY_WORDS-1)*32 +: 32] ^ i_mix_word;
`endif
   end

`ifndef RAVAN_WORD_MIX_EN
   logic w_unused_mix;
   assign w_unused_mix = ^i_mix_word;
`endif

   assign w_idx_nxt     = r_idx + IDX_W'(1);
   assign w_wr_addr_nxt = ADDR_W'(WR_BASE) + ADDR_W'(w_idx_nxt);
   assign w_rd_addr     = ADDR_W'(RD_BASE) + ADDR_W'(r_idx);

   // Sequencer: outputs are loaded on entry to the state that presents them
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_hash  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_cs    <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         for (int i = 0; i < KEY_WORDS; i++) begin
            r_key[i] <= '0;
         end
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_key   <= w_key_lat;
                  r_err   <= 1'b0;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_cs    <= 1'b1;
                  r_we    <= 1'b1;
                  r_addr  <= ADDR_W'(WR_BASE);
                  r_wdata <= w_key_lat[0];
                  r_state <= S_WRITE;
               end
            end
            S_WRITE: begin
               if (i_bus_error) r_err <= 1'b1;
               r_cs    <= 1'b0;
               r_we    <= 1'b0;
               r_cnt   <= 8'(WAIT_CYCLES);
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (r_cnt == '0) begin
                  r_cs    <= 1'b1;
                  r_we    <= 1'b0;
                  r_addr  <= w_rd_addr;
                  r_state <= S_READ;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            S_READ: begin
               if (i_bus_error) r_err <= 1'b1;
               r_cs    <= 1'b0;
               r_state <= S_CAPTURE;
            end
            S_CAPTURE: begin
               if (i_bus_error) r_err <= 1'b1;
               r_hash[{r_idx, 5'b0} +: 32] <= i_bus_rdata;
               if (r_idx == LAST_IDX) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_idx   <= w_idx_nxt;
                  r_cs    <= 1'b1;
                  r_we    <= 1'b1;
                  r_addr  <= w_wr_addr_nxt;
                  r_wdata <= r_key[w_idx_nxt];
                  r_state <= S_WRITE;
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_err       = r_err;
   assign o_hash_out  = r_hash;
   assign o_bus_cs    = r_cs;
   assign o_bus_we    = r_we;
   assign o_bus_addr  = r_addr;
   assign o_bus_wdata = r_wdata;

endmodule

// File: tb/tb_ravan_key_sequencer.sv
// Scoreboard bench for ravan_key_sequencer: default instance (16 words, wait 2) and a small instance (4 words, wait 0, offset bases).
module tb_ravan_key_sequencer;

`ifdef RAVAN_WORD_MIX_EN
   localparam bit MIX_ON = 1'b1;
`else
   localparam bit MIX_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // instance A: defaults
   logic          a_start = 1'b0;
   logic [511:0]  a_key = '0;
   logic [31:0]   a_mix = '0;
   logic          a_busy, a_done, a_err, a_cs, a_we;
   logic [511:0]  a_hash;
   logic [7:0]    a_addr;
   logic [31:0]   a_wdata;
   logic [31:0]   a_rdata = 32'hDEAD_BEEF;
   logic          a_berr = 1'b0;
   logic          a_inj = 1'b0;
   logic [31:0]   a_last_w = '0;
   logic          a_rd_pend = 1'b0;

   // instance B: 4 words, no wait, offset bases
   logic          b_start = 1'b0;
   logic [127:0]  b_key = '0;
   logic          b_busy, b_done, b_err, b_cs, b_we;
   logic [127:0]  b_hash;
   logic [7:0]    b_addr;
   logic [31:0]   b_wdata;
   logic [31:0]   b_rdata = 32'hDEAD_BEEF;
   logic [31:0]   b_last_w = '0;
   logic          b_rd_pend = 1'b0;

   ravan_key_sequencer u_dut_a (
      .clk         (clk),
      .rst         (rst),
      .i_start     (a_start),
      .i_key_in    (a_key),
      .i_mix_word  (a_mix),
      .o_busy      (a_busy),
      .o_done      (a_done),
      .o_err       (a_err),
      .o_hash_out  (a_hash),
      .o_bus_cs    (a_cs),
      .o_bus_we    (a_we),
      .o_bus_addr  (a_addr),
      .o_bus_wdata (a_wdata),
      .i_bus_rdata (a_rdata),
      .i_bus_error (a_berr)
   );

   ravan_key_sequencer #(
      .KEY_WORDS   (4),
      .ADDR_W      (8),
      .WR_BASE     (32'h10),
      .RD_BASE     (32'h20),
      .WAIT_CYCLES (0)
   ) u_dut_b (
      .clk         (clk),
      .rst         (rst),
      .i_start     (b_start),
      .i_key_in    (b_key),
      .i_mix_word  (32'h0),
      .o_busy      (b_busy),
      .o_done      (b_done),
      .o_err       (b_err),
      .o_hash_out  (b_hash),
      .o_bus_cs    (b_cs),
      .o_bus_we    (b_we),
      .o_bus_addr  (b_addr),
      .o_bus_wdata (b_wdata),
      .i_bus_rdata (b_rdata),
      .i_bus_error (1'b0)
   );

   typedef struct {
      int           kind;   // 0 write, 1 read, 2 done
      logic [7:0]   addr;
      logic [31:0]  data;
      int           cyc;
      logic         err;
      logic [511:0] hash;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [511:0] mk_key(input logic [31:0] base, input int n);
      logic [511:0] k = '0;
      for (int i = 0; i < n; i++) k[i*32 +: 32] = base + 32'(i);
      return k;
   endfunction

   // Slave models: remember last write, return its inverse the cycle after a read
   always @(negedge clk) begin
      a_rdata   = a_rd_pend ? ~a_last_w : 32'hDEAD_BEEF;
      a_rd_pend = 1'b0;
      if (a_cs && a_we) a_last_w = a_wdata;
      if (a_cs && !a_we) a_rd_pend = 1'b1;
      a_berr = a_inj && a_cs && !a_we && (a_addr == 8'd5);
   end

   always @(negedge clk) begin
      b_rdata   = b_rd_pend ? ~b_last_w : 32'hDEAD_BEEF;
      b_rd_pend = 1'b0;
      if (b_cs && b_we) b_last_w = b_wdata;
      if (b_cs && !b_we) b_rd_pend = 1'b1;
   end

   task automatic mon_event(input bit sel, input int kind, input logic [7:0] addr,
                            input logic [31:0] data, input logic err, input logic [511:0] hash);
      exp_t  e;
      string p = sel ? "b" : "a";
      int    sz = sel ? q_b.size() : q_a.size();
      if (sz == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_unexpected_event: got kind %0d addr %0h expected no event", p, kind, addr);
         return;
      end
      e = sel ? q_b.pop_front() : q_a.pop_front();
      chk($sformatf("%s_kind_at_cyc%0d", p, cyc), 512'(kind), 512'(e.kind));
      if (e.kind == kind) begin
         if (kind == 0) begin
            chk($sformatf("%s_wr_addr", p), 512'(addr), 512'(e.addr));
            chk($sformatf("%s_wr_data_%0h", p, e.addr), 512'(data), 512'(e.data));
         end else if (kind == 1) begin
            chk($sformatf("%s_rd_addr", p), 512'(addr), 512'(e.addr));
         end else begin
            chk($sformatf("%s_done_cycle", p), 512'(cyc), 512'(e.cyc));
            chk($sformatf("%s_done_err", p), 512'(err), 512'(e.err));
            chk($sformatf("%s_done_hash", p), hash, e.hash);
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst && (a_cs || a_done))
         mon_event(1'b0, a_done ? 2 : (a_we ? 0 : 1), a_addr, a_wdata, a_err, a_hash);
   end

   always @(negedge clk) begin
      if (!rst && (b_cs || b_done))
         mon_event(1'b1, b_done ? 2 : (b_we ? 0 : 1), b_addr, b_wdata, b_err, {384'b0, b_hash});
   end

   // Expected bus sequence, done cycle and result for one job
   task automatic push_job(input bit sel, input logic [511:0] key, input logic [31:0] mix,
                           input logic exp_err, input int s);
      exp_t         e;
      logic [31:0]  w;
      logic [511:0] h = '0;
      int nw  = sel ? 4 : 16;
      int wt  = sel ? 0 : 2;
      int wrb = sel ? 32'h10 : 0;
      int rdb = sel ? 32'h20 : 0;
      for (int i = 0; i < nw; i++) begin
         w = key[i*32 +: 32];
         if (MIX_ON && i == nw - 1) w = w ^ mix;
         e.kind = 0; e.addr = 8'(wrb + i); e.data = w; e.cyc = 0; e.err = 1'b0; e.hash = '0;
         if (sel) q_b.push_back(e); else q_a.push_back(e);
         e.kind = 1; e.addr = 8'(rdb + i);
         if (sel) q_b.push_back(e); else q_a.push_back(e);
         h[i*32 +: 32] = ~w;
      end
      e.kind = 2; e.addr = '0; e.data = '0; e.cyc = s + nw * (wt + 4) + 1; e.err = exp_err; e.hash = h;
      if (sel) q_b.push_back(e); else q_a.push_back(e);
   endtask

   task automatic start_job(input bit sel, input logic [511:0] key, input logic [31:0] mix,
                            input logic exp_err, output int s);
      @(posedge clk); #1;
      s = cyc;
      if (sel) begin
         b_key = key[127:0];
         b_start = 1'b1;
      end else begin
         a_key = key;
         a_mix = mix;
         a_start = 1'b1;
      end
      push_job(sel, key, mix, exp_err, s);
      @(posedge clk); #1;
      a_start = 1'b0;
      b_start = 1'b0;
   endtask

   task automatic wait_drain(input bit sel, input int limit, input string name);
      for (int t = 0; t < limit; t++) begin
         if ((sel ? q_b.size() : q_a.size()) == 0) break;
         @(posedge clk);
      end
      chk(name, 512'(sel ? q_b.size() : q_a.size()), 512'(0));
   endtask

   initial begin
      int s;
      int idle_cs;
      logic [511:0] prev_hash;

      // asynchronous reset before any clock edge
      #1 rst = 1'b1;
      #1;
      chk("rst_busy",  512'(a_busy),  512'(0));
      chk("rst_done",  512'(a_done),  512'(0));
      chk("rst_err",   512'(a_err),   512'(0));
      chk("rst_hash",  a_hash,        512'(0));
      chk("rst_cs",    512'(a_cs),    512'(0));
      chk("rst_we",    512'(a_we),    512'(0));
      chk("rst_addr",  512'(a_addr),  512'(0));
      chk("rst_wdata", 512'(a_wdata), 512'(0));
      chk("rst_b_cs",  512'(b_cs),    512'(0));
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      // idle: no bus activity without start
      idle_cs = 0;
      repeat (100) begin
         @(negedge clk);
         if (a_cs || b_cs) idle_cs++;
      end
      chk("idle_cs_count", 512'(idle_cs), 512'(0));

      // basic 16-word job
      start_job(1'b0, mk_key(32'h1000_0000, 16), 32'h0, 1'b0, s);
      wait_drain(1'b0, 200, "a_basic_timeout");

      // 4-word, zero-wait, offset-base job
      start_job(1'b1, mk_key(32'hB000_0000, 4), 32'h0, 1'b0, s);
      wait_drain(1'b1, 60, "b_sweep_timeout");

      // start while busy is ignored
      start_job(1'b0, mk_key(32'h2000_0000, 16), 32'h0, 1'b0, s);
      while (cyc != s + 20) begin @(posedge clk); #1; end
      chk("busy_mid_job", 512'(a_busy), 512'(1));
      a_key = mk_key(32'h3000_0000, 16);
      a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      wait_drain(1'b0, 200, "a_busy_timeout");
      repeat (120) @(posedge clk);
      #1;
      chk("idle_after_done_busy", 512'(a_busy), 512'(0));

      // bus error during word 5 read
      a_inj = 1'b1;
      start_job(1'b0, mk_key(32'h4000_0000, 16), 32'h0, 1'b1, s);
      wait_drain(1'b0, 200, "a_err_timeout");
      a_inj = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("err_held", 512'(a_err), 512'(1));
      prev_hash = '0;
      for (int i = 0; i < 16; i++) prev_hash[i*32 +: 32] = ~(32'h4000_0000 + 32'(i));

      // clean job clears err; result holds until overwritten
      start_job(1'b0, mk_key(32'h7000_0000, 16), 32'h0, 1'b0, s);
      chk("err_cleared_on_start", 512'(a_err), 512'(0));
      chk("hash_held_on_start", a_hash, prev_hash);
      wait_drain(1'b0, 200, "a_clean_timeout");

      // reset during word 7 WAIT
      start_job(1'b0, mk_key(32'h5000_0000, 16), 32'h0, 1'b0, s);
      while (cyc != s + 45) begin @(posedge clk); #1; end
      #2 rst = 1'b1;
      #1;
      chk("midrst_events_left", 512'(q_a.size()), 512'(18));
      q_a.delete();
      chk("midrst_busy",  512'(a_busy),  512'(0));
      chk("midrst_done",  512'(a_done),  512'(0));
      chk("midrst_hash",  a_hash,        512'(0));
      chk("midrst_cs",    512'(a_cs),    512'(0));
      chk("midrst_addr",  512'(a_addr),  512'(0));
      chk("midrst_wdata", 512'(a_wdata), 512'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (40) @(posedge clk);

      // restart with tweak word
      start_job(1'b0, mk_key(32'h6000_0000, 16), 32'hFFFF_FFFF, 1'b0, s);
      wait_drain(1'b0, 200, "a_mix_timeout");
      repeat (10) @(posedge clk);

      chk("final_q_a_empty", 512'(q_a.size()), 512'(0));
      chk("final_q_b_empty", 512'(q_b.size()), 512'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ravan_key_sequencer.md
Name: ravan_key_sequencer

Overview:
Parametrised key-streaming engine for the RAVAN crypto datapath. It latches a KEY_WORDS x 32-bit key on a start pulse and writes each word into a register-mapped hash core over a cs/we/address bus. After each write it waits a programmable number of cycles, reads the corresponding result word back, and assembles the results into a wide output. Start/busy/done handshake, sticky bus-error capture and output hold until the next job.

Parameters:
KEY_WORDS, 16, number of 32-bit words per job (1..256)
ADDR_W, 8, bus address width
WR_BASE, 0, bus address of word 0 write; word i goes to WR_BASE+i
RD_BASE, 0, bus address of word 0 readback; word i comes from RD_BASE+i
WAIT_CYCLES, 2, idle cycles between write and read of a word (0..255)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  single-cycle job request; accepted only when busy=0
key_in  in  32*KEY_WORDS  key; word i = key_in[i*32 +: 32]; sampled on the accepted start
mix_word  in  32  tweak word (used only with RAVAN_WORD_MIX_EN)
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when the job completes
err  out  1  sticky bus error for the current job; valid with done, held until the next start
hash_out  out  32*KEY_WORDS  result words; word i = readback of word i
bus_cs  out  1  bus chip select
bus_we  out  1  bus write enable
bus_addr  out  ADDR_W  bus address
bus_wdata  out  32  bus write data
bus_rdata  in  32  bus read data; slave returns it one cycle after a read request (cs=1, we=0)
bus_error  in  1  slave error flag

Behaviour:
- Reset: state IDLE; busy=0, done=0, err=0, hash_out=0, bus_cs=0, bus_we=0, bus_addr=0, bus_wdata=0; word index idx=0, wait counter=0. Reset mid-job aborts immediately with no completion pulse.
- IDLE: on start, latch key_in into the internal key register, clear err, set idx=0 and busy=1, then go to WRITE. hash_out keeps the previous result until overwritten word by word.
- WRITE, 1 cycle: bus_cs=1, bus_we=1, bus_addr=WR_BASE+idx, bus_wdata=key word idx. Then go to WAIT with counter=WAIT_CYCLES.
- WAIT: bus_cs=0, bus_we=0. If counter==0, go to READ; otherwise decrement. With WAIT_CYCLES=0, WAIT lasts exactly one cycle.
- READ, 1 cycle: bus_cs=1, bus_we=0, bus_addr=RD_BASE+idx. Then go to CAPTURE.
- CAPTURE, 1 cycle: bus_cs=0 and hash_out word idx <= bus_rdata.
  - If idx==KEY_WORDS-1, go to DONE.
  - Otherwise increment idx and go to WRITE.
- DONE, 1 cycle: done=1 and busy=0 on the following cycle, then return to IDLE.
- Latency: first bus write occurs the cycle after start. Per-word cost is WAIT_CYCLES+4 cycles. done is asserted KEY_WORDS*(WAIT_CYCLES+4)+1 cycles after the start cycle.
- Error capture: bus_error is sampled on every cycle where bus_cs=1 and in CAPTURE. Any 1 sets err until the next accepted start. Errors do not abort the job.
- start while busy=1 is ignored; there is no queueing.
- Address arithmetic is modulo 2^ADDR_W (wraps).
- All outputs are registered. bus_* outputs change only on clk edges.

Optional Feature:
- Macro: RAVAN_WORD_MIX_EN.
- Defined: the last key word (index KEY_WORDS-1) is XORed with mix_word, sampled at the accepted start, before being written. All other words pass unmodified. This is the generalised tweak-word slot of the RAVAN key path.
- Undefined: mix_word is unused, and every word is written exactly as latched from key_in.

Test Plan:
- Reset then idle: assert rst mid-cycle -> all outputs 0 asynchronously. With no start, bus_cs stays 0 for 100 cycles.
- Basic job (KEY_WORDS=16, WAIT_CYCLES=2): key word i=0x1000_0000+i. Slave model returns ~wdata one cycle after a read.
  - Exactly 16 write/read pairs at addresses 0..15.
  - done 97 cycles after start.
  - hash_out word i = ~(0x1000_0000+i). err=0.
- Parameter sweep: KEY_WORDS=4, WAIT_CYCLES=0, WR_BASE=0x10, RD_BASE=0x20.
  - Writes at 0x10..0x13, reads at 0x20..0x23.
  - done 17 cycles after start.
- Start while busy: pulse start again mid-job with a different key -> ignored. Result matches the first key; exactly one done pulse.
- Error: slave raises bus_error for 1 cycle during word 5's read -> job completes, err=1 with done. err clears on the next start; a clean second job gives err=0.
- Mid-job reset then mix: assert rst during word 7's WAIT -> no done, outputs 0. Restart with RAVAN_WORD_MIX_EN and mix_word=0xFFFF_FFFF -> last written word = ~key word 15. Other words unchanged.
